// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - PC register and Fetch-to-Decode pipeline register with stall/flush handling
// Optional feature macro: FETCH_PERF_CNT_EN (total stall and flush cycle counters).
module fetch_decode_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] InstrIn,
    output logic [31:0] PC,
    output logic [31:0] InstrOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic        StallTimeout,
    output logic        CtrlMismatch,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [7:0]  run_q, run_d;
    logic        timeout_q, timeout_d;
    logic        mismatch_q, mismatch_d;

    logic        stall_cycle;
    logic [31:0] pc_inc;

    assign stall_cycle = !PCWrite && !IFIDWrite && !Flush;
    assign pc_inc      = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (Flush) begin
            pc_d = {BranchTarget[31:2], 2'b00};
        end else if (PCWrite) begin
            pc_d = pc_inc;
        end
    end

    // A flush always inserts a bubble, even when the hazard unit holds the register.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (Flush) begin
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (IFIDWrite) begin
            instr_d    = InstrIn;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
        end
    end

    always_comb begin
        run_d = 8'd0;
        if (stall_cycle) begin
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end
        timeout_d  = timeout_q  || (stall_cycle && (run_d >= MAX_STALL_C));
        mismatch_d = mismatch_q || (PCWrite && !IFIDWrite && !Flush);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            run_q      <= 8'd0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            run_q      <= run_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cycle ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = Flush       ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = 32'd0;
    assign FlushCount = 32'd0;
`endif

    assign PC           = pc_q;
    assign InstrOut     = instr_q;
    assign PCPlus4Out   = pc_plus4_q;
    assign ValidOut     = valid_q;
    assign StallTimeout = timeout_q;
    assign CtrlMismatch = mismatch_q;

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Consumer side of the load-use stall protocol. Owns the PC register and the Fetch-to-Decode pipeline register.
- Acts on the hazard unit's PCWrite / decode-register write-enable pair and on the branch-taken flush from Decode.
- Sits between instruction memory and Decode.
- Also tracks consecutive-stall length and flags stall lockups and mismatched hazard controls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 4, consecutive stall cycles after which StallTimeout sets (1..255).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PCWrite  input  1  from hazard unit; 1 = PC advances, 0 = PC holds.
- IFIDWrite  input  1  from hazard unit; 1 = Fetch-to-Decode register loads, 0 = holds.
- Flush  input  1  branch/jump taken in Decode; squash the fetched instruction and redirect.
- BranchTarget  input  32  redirect address, valid when Flush=1.
- InstrIn  input  32  instruction-memory read data for the current PC.
- PC  output  32  current fetch address, drives instruction memory.
- InstrOut  output  32  instruction presented to Decode.
- PCPlus4Out  output  32  PC+4 of the instruction in InstrOut.
- ValidOut  output  1  InstrOut is a real instruction (0 = bubble/nop).
- StallTimeout  output  1  sticky; stall run reached MAX_STALL.
- CtrlMismatch  output  1  sticky; PCWrite=1 while IFIDWrite=0 with no Flush.
- StallCount  output  32  total stall cycles (see Optional Feature).
- FlushCount  output  32  total flush cycles (see Optional Feature).

Behaviour:
- Reset (async, immediate, including mid-stall or mid-flush): PC=RESET_PC, InstrOut=0, PCPlus4Out=0, ValidOut=0, StallTimeout=0, CtrlMismatch=0, run counter=0, StallCount=0, FlushCount=0.
- All other updates occur on the rising edge of Clk.
- PC update, priority order:
  - Flush: PC <= {BranchTarget[31:2],2'b00}. Flush overrides a simultaneous stall.
  - Else PCWrite=1: PC <= PC+4.
  - Else PC holds.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] is always 00.
- Fetch-to-Decode register, priority order:
  - Flush: InstrOut <= 0, PCPlus4Out <= 0, ValidOut <= 0. A bubble is inserted even if IFIDWrite=0.
  - Else IFIDWrite=1: InstrOut <= InstrIn, PCPlus4Out <= PC+4, ValidOut <= 1.
  - Else all three hold.
- Latency: InstrIn sampled at PC is visible on InstrOut one cycle later. Instruction memory is combinational read.
- Stall cycle = PCWrite=0 & IFIDWrite=0 & Flush=0.
- Run counter (8-bit, saturating, internal):
  - Increments on each stall cycle; cleared on any non-stall cycle.
  - StallTimeout sets on the edge where the counter reaches MAX_STALL and stays set until Reset.
- CtrlMismatch sets on any edge with PCWrite=1, IFIDWrite=0, Flush=0 (the fetched instruction would be lost); sticky until Reset.
- PCWrite=0, IFIDWrite=1 is legal: the same instruction is re-latched. Not flagged.
- Every output is registered; no combinational input-to-output path.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - StallCount increments by 1 on every stall cycle.
  - FlushCount increments by 1 on every Flush cycle.
  - Both 32-bit, wrap from 32'hFFFF_FFFF to 0, cleared by Reset.
- Undefined: both counters and their logic are removed; StallCount and FlushCount are tied to 0.

Test Plan:
- Reset released, PCWrite=IFIDWrite=1, InstrIn=32'h2008_0005 for 3 cycles -> PC goes 0,4,8,12; after the first edge InstrOut=32'h2008_0005, PCPlus4Out=4, ValidOut=1.
- Load-use stall: at PC=8 drive PCWrite=IFIDWrite=0 for 1 cycle -> PC stays 8, InstrOut/PCPlus4Out unchanged, StallTimeout=0. With FETCH_PERF_CNT_EN, StallCount=1.
- Flush with simultaneous stall: PC=16, Flush=1, BranchTarget=32'h0000_0043, PCWrite=IFIDWrite=0 -> next PC=32'h40, InstrOut=0, ValidOut=0, PCPlus4Out=0. With macro, FlushCount=1.
- Lockup: MAX_STALL=4, hold stall 4 cycles -> StallTimeout=1 after the 4th edge and stays 1 after normal operation resumes. A 3-cycle stall then a release leaves it 0.
- Wrap and mismatch: PC=32'hFFFF_FFFC, PCWrite=1, IFIDWrite=0 -> PC=0, InstrOut held, CtrlMismatch=1 and sticky.
- Async reset asserted mid-stall between clock edges -> all outputs at reset values immediately, PC=RESET_PC before the next edge.
